// File: rtl/count_game_pkg.sv
// Shared definitions for the count game: FSM state encoding and default reload value.
// The display stage imports this package as well.
package count_game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int START_VAL_DEF = 7;

endpackage : count_game_pkg

// File: rtl/key_debounce.sv
// Raw push-button to one-cycle press pulse: two-flop synchronizer, stability
// counter, debounced level, and a pulse on each accepted rising level change.
module key_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds the length of the current run of samples that disagree with the level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule : key_debounce

// File: rtl/count_game_ctrl.sv
// Countdown controller: debounced start/pause commands drive a START_VAL-to-0
// countdown, one step per TICK_DIV clocks, with registered display outputs.
//
// state | meaning
// IDLE  | display blank, num parked at START_VAL
// RUN   | tick counter advancing, num decrements on each wrap
// PAUSE | tick counter and num frozen, display on
// DONE  | num held at 0, display on
module count_game_ctrl
  import count_game_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int START_VAL  = START_VAL_DEF,
  parameter int DEB_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_pause,
  output logic [2:0] num,
  output logic       st,
  output logic       done,
  output logic [1:0] state_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [2:0]    NUM_INIT  = 3'(START_VAL);

  logic start_p, pause_p;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_start),
    .press  (start_p)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_pause),
    .press  (pause_p)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    num_q, num_d;
  logic          st_q, st_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    num_d   = num_q;
    done_d  = 1'b0;
    if (start_p) begin
      // Start has priority over pause and restarts from any state.
      state_d = RUN;
      num_d   = NUM_INIT;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: num_d = NUM_INIT;
        RUN: begin
          if (pause_p) begin
            state_d = PAUSE;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (num_q >= 3'd1) num_d = num_q - 3'd1;
            if (num_q == 3'd1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PAUSE: if (pause_p) state_d = RUN;
        DONE:  num_d = '0;
        default: state_d = IDLE;
      endcase
    end
    st_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      num_q   <= NUM_INIT;
      st_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      num_q   <= num_d;
      st_q    <= st_d;
      done_q  <= done_d;
    end
  end

  assign num     = num_q;
  assign st      = st_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule : count_game_ctrl

// File: tb/tb_count_game_ctrl.sv
// Scoreboard bench for count_game_ctrl: randomized key stimulus against an
// elapsed-time reference model, outputs compared every cycle by a monitor.
module tb_count_game_ctrl;

  localparam int TD    = 10;
  localparam int DEB   = 4;
  localparam int START = 7;
  localparam int HLEN  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_start, key_pause;
  logic [2:0] num;
  logic       st, done;
  logic [1:0] state_o;

  count_game_ctrl #(.TICK_DIV(TD), .START_VAL(START), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_pause (key_pause),
    .num       (num),
    .st        (st),
    .done      (done),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {state, num, st, done}
  logic [6:0] sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw key history since reset release, debounced levels,
  // and the countdown expressed as elapsed RUN cycles since the last start.
  bit hist_s[HLEN];
  bit hist_p[HLEN];
  int nhist;
  bit lvl_s, lvl_p;
  int m_state;
  int m_run;
  bit m_done;

  function automatic bit raw_at(input int which, input int back);
    int idx;
    idx = nhist - 1 - back;
    if (idx < 0) return 1'b0;
    return which ? hist_p[idx % HLEN] : hist_s[idx % HLEN];
  endfunction

  // A level flips once the last DEB synchronized samples all disagree with it.
  function automatic bit deb_press(input int which);
    bit lvl, all_diff;
    lvl = which ? lvl_p : lvl_s;
    all_diff = 1'b1;
    for (int k = 0; k < DEB; k++)
      if (raw_at(which, 3 + k) == lvl) all_diff = 1'b0;
    if (!all_diff) return 1'b0;
    if (which) lvl_p = ~lvl_p; else lvl_s = ~lvl_s;
    return ~lvl;
  endfunction

  function automatic logic [6:0] model_out();
    int n;
    n = (m_state == 0) ? START : START - m_run / TD;
    return {2'(m_state), 3'(n), (m_state != 0), m_done};
  endfunction

  task automatic model_reset();
    nhist = 0; lvl_s = 0; lvl_p = 0;
    m_state = 0; m_run = 0; m_done = 0;
  endtask

  task automatic model_advance(input bit ks, input bit kp);
    bit ps, pp;
    hist_s[nhist % HLEN] = ks;
    hist_p[nhist % HLEN] = kp;
    nhist++;
    ps = deb_press(0);
    pp = deb_press(1);
    m_done = 0;
    if (ps) begin
      m_state = 1;
      m_run   = 0;
    end else if (m_state == 1) begin
      if (pp) m_state = 2;
      else begin
        m_run++;
        if (m_run == START * TD) begin
          m_state = 3;
          m_done  = 1;
        end
      end
    end else if (m_state == 2 && pp) begin
      m_state = 1;
    end
  endtask

  task automatic step(input bit rst_v, input bit ks, input bit kp);
    @(posedge clk);
    #1;
    rst = rst_v; key_start = ks; key_pause = kp;
    if (!rst_v) model_reset();
    sb_q.push_back(model_out());
    if (rst_v) model_advance(ks, kp);
  endtask

  task automatic hold(input bit ks, input bit kp, input int n);
    repeat (n) step(1'b1, ks, kp);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      logic [6:0] exp_v, got_v;
      exp_v = sb_q.pop_front();
      got_v = {state_o, num, st, done};
      n_checks++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL outputs t=%0t got state=%0d num=%0d st=%0b done=%0b required state=%0d num=%0d st=%0b done=%0b",
                    $time, got_v[6:5], got_v[4:2], got_v[1], got_v[0],
                    exp_v[6:5], exp_v[4:2], exp_v[1], exp_v[0]);
    end
  end

  initial begin
    int r, n;
    rst = 1'b0; key_start = 1'b0; key_pause = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    hold(0, 0, 10);
    // Short glitches on start, then pause in IDLE
    repeat (8) begin hold(1, 0, 2); hold(0, 0, 2); end
    hold(0, 1, 8); hold(0, 0, 6);
    // Full countdown, pause in DONE, restart from DONE
    hold(1, 0, 10); hold(0, 0, 75);
    hold(0, 1, 8);  hold(0, 0, 6);
    hold(1, 0, 6);  hold(0, 0, 20);
    // Pause mid-step, hold, resume
    hold(0, 1, 5);  hold(0, 0, 50);
    hold(0, 1, 5);  hold(0, 0, 20);
    // Simultaneous start and pause during RUN
    hold(1, 1, 6);  hold(0, 0, 12);
    // Reset mid-run with start held across release
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    hold(1, 0, 8);  hold(0, 0, 15);
    for (int ep = 0; ep < 180; ep++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: hold(0, 0, $urandom_range(1, 35));
        4: begin hold(1, 0, $urandom_range(DEB, DEB + 6)); hold(0, 0, DEB); end
        5: begin hold(0, 1, $urandom_range(DEB, DEB + 6)); hold(0, 0, DEB); end
        6: begin hold(1, 1, $urandom_range(DEB, DEB + 4)); hold(0, 0, DEB); end
        7: begin
             n = $urandom_range(1, DEB - 1);
             if ($urandom_range(0, 1) != 0) hold(1, 0, n); else hold(0, 1, n);
             hold(0, 0, $urandom_range(1, 3));
           end
        8: repeat ($urandom_range(1, 12))
             step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: if ($urandom_range(0, 3) == 0) begin
                   n = $urandom_range(0, 1);
                   repeat ($urandom_range(1, 3)) step(1'b0, 1'(n), 1'b0);
                   hold(1'(n), 0, $urandom_range(1, DEB + 4));
                 end else begin
                   hold(0, 0, $urandom_range(30, 80));
                 end
      endcase
    end
    hold(0, 0, 5);
    @(negedge clk); #1;
    n_checks++;
    if (sb_q.size() == 0 && n_checks > 1000) n_pass++;
    else $display("FAIL drain got pending=%0d checks=%0d required pending=0 checks>1000",
                  sb_q.size(), n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_count_game_ctrl
